// File: rtl/coin_acceptor_pkg.sv
// -----------------------------------------------------------------------------
// coin_acceptor_pkg
//   Shared definitions for the coin acceptor front end and the vending FSM that
//   consumes its pulses: FSM state encodings (3 bits), coin-type codes and the
//   default debounce / lockout / counter-width values.
// -----------------------------------------------------------------------------
package coin_acceptor_pkg;

  localparam int DEBOUNCE_DEFAULT = 4;
  localparam int LOCKOUT_DEFAULT  = 8;
  localparam int CNT_W_DEFAULT    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUALIFY = 3'd1,
    ST_EMIT    = 3'd2,
    ST_REJ     = 3'd3,
    ST_RELEASE = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_e;

  typedef enum logic {
    COIN_Q = 1'b0,
    COIN_D = 1'b1
  } coin_e;

endpackage

// File: rtl/coin_acceptor_sync2.sv
// -----------------------------------------------------------------------------
// coin_acceptor_sync2
//   1-bit two-flop synchroniser for an asynchronous sensor line. Both flops
//   reset to 0, so a line held high through reset release is seen as a fresh
//   rising edge.
// Ports:
//   clk      in   system clock, rising edge
//   rstn     in   asynchronous active-low reset
//   i_async  in   raw asynchronous input
//   o_sync   out  synchronised output (second flop)
// -----------------------------------------------------------------------------
module coin_acceptor_sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic i_async,
  output logic o_sync
);

  logic r_s1;
  logic r_s2;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
    end
  end

  assign o_sync = r_s2;

endmodule

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
//   Front end for the vending machine FSM. Synchronises and debounces the raw
//   quarter / dollar chute sensors and emits exactly one single-cycle credit
//   pulse per physical coin, or a reject pulse when both chutes fire or a coin
//   is disturbed by the other chute while qualifying. After every pulse the
//   chutes must read quiet for DEBOUNCE_CYCLES cycles, then a LOCKOUT_CYCLES
//   hold-off runs before the next coin is accepted.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable samples needed to accept / release (1..255)
//   LOCKOUT_CYCLES   hold-off after release (1..255)
//   CNT_W            width of the internal counter and the coin counters
//
// Ports:
//   clk         in   system clock, rising edge
//   rstn        in   asynchronous active-low reset
//   coin_q_raw  in   raw quarter-chute sensor (async, active-high)
//   coin_d_raw  in   raw dollar-chute sensor (async, active-high)
//   quarter     out  one-cycle pulse per accepted quarter
//   dollar      out  one-cycle pulse per accepted dollar
//   reject      out  one-cycle pulse per rejected event
//   busy        out  high whenever the FSM is not in IDLE
//   coin_cnt    out  saturating count of credit pulses   (COIN_ACCEPTOR_COUNT_EN)
//   rej_cnt     out  saturating count of reject pulses   (COIN_ACCEPTOR_COUNT_EN)
//
// Configuration macro: COIN_ACCEPTOR_COUNT_EN adds the coin_cnt / rej_cnt
// ports and counters; without it they are absent.
// -----------------------------------------------------------------------------
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic coin_q_raw,
  input  logic coin_d_raw,
  output logic quarter,
  output logic dollar,
  output logic reject,
  output logic busy
`ifdef COIN_ACCEPTOR_COUNT_EN
  ,
  output logic [CNT_W-1:0] coin_cnt,
  output logic [CNT_W-1:0] rej_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_END = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LCK_END = CNT_W'(LOCKOUT_CYCLES - 1);

  // Synchronised sensor lines; the FSM never looks at the raw inputs.
  logic w_s2_q;
  logic w_s2_d;

  coin_acceptor_sync2 u_sync_q (
    .clk     (clk),
    .rstn    (rstn),
    .i_async (coin_q_raw),
    .o_sync  (w_s2_q)
  );

  coin_acceptor_sync2 u_sync_d (
    .clk     (clk),
    .rstn    (rstn),
    .i_async (coin_d_raw),
    .o_sync  (w_s2_d)
  );

  state_e           r_state;
  state_e           w_state_nxt;
  coin_e            r_type;
  coin_e            w_type_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  // Line of the latched coin type and the opposite chute.
  logic w_own;
  logic w_other;

  logic r_quarter;
  logic r_dollar;
  logic r_reject;
  logic r_busy;
  logic w_quarter_nxt;
  logic w_dollar_nxt;
  logic w_reject_nxt;
  logic w_busy_nxt;

  assign w_own     = (r_type == COIN_Q) ? w_s2_q : w_s2_d;
  assign w_other   = (r_type == COIN_Q) ? w_s2_d : w_s2_q;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_type  <= COIN_Q;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_type  <= w_type_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_type_nxt  = r_type;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_s2_q && w_s2_d) begin
          w_state_nxt = ST_REJ;
        end else if (w_s2_q || w_s2_d) begin
          w_state_nxt = ST_QUALIFY;
          w_type_nxt  = w_s2_q ? COIN_Q : COIN_D;
          w_cnt_nxt   = '0;
        end
      end
      ST_QUALIFY: begin
        // A drop of the own line is a glitch; the other chute firing while
        // the own line is still high is interference and wins over EMIT.
        if (!w_own) begin
          w_state_nxt = ST_IDLE;
        end else if (w_other) begin
          w_state_nxt = ST_REJ;
        end else if (r_cnt == DEB_END) begin
          w_state_nxt = ST_EMIT;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_EMIT, ST_REJ: begin
        w_state_nxt = ST_RELEASE;
        w_cnt_nxt   = '0;
      end
      ST_RELEASE: begin
        // Both chutes must read low for DEBOUNCE_CYCLES consecutive samples.
        if (w_s2_q || w_s2_d) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == DEB_END) begin
          w_state_nxt = ST_LOCKOUT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_LOCKOUT: begin
        if (r_cnt == LCK_END) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: decoded from the next state so the registered outputs line
  // up with the state they describe.
  always_comb begin
    w_quarter_nxt = (w_state_nxt == ST_EMIT) && (w_type_nxt == COIN_Q);
    w_dollar_nxt  = (w_state_nxt == ST_EMIT) && (w_type_nxt == COIN_D);
    w_reject_nxt  = (w_state_nxt == ST_REJ);
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_quarter <= 1'b0;
      r_dollar  <= 1'b0;
      r_reject  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_quarter <= w_quarter_nxt;
      r_dollar  <= w_dollar_nxt;
      r_reject  <= w_reject_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign quarter = r_quarter;
  assign dollar  = r_dollar;
  assign reject  = r_reject;
  assign busy    = r_busy;

`ifdef COIN_ACCEPTOR_COUNT_EN
  logic [CNT_W-1:0] r_coin_cnt;
  logic [CNT_W-1:0] r_rej_cnt;

  // Counters follow the registered pulses, so they step one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_coin_cnt <= '0;
      r_rej_cnt  <= '0;
    end else begin
      if ((r_quarter || r_dollar) && (r_coin_cnt != '1)) begin
        r_coin_cnt <= r_coin_cnt + CNT_ONE;
      end
      if (r_reject && (r_rej_cnt != '1)) begin
        r_rej_cnt <= r_rej_cnt + CNT_ONE;
      end
    end
  end

  assign coin_cnt = r_coin_cnt;
  assign rej_cnt  = r_rej_cnt;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
//   Self-checking bench for coin_acceptor. A timestamp-based reference model
//   predicts every output on every cycle; directed scenarios pin latency and
//   pulse counts with hand-computed values; a randomized phase follows.
//   Inputs change 2 ns after a rising edge; outputs are compared on the
//   falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_coin_acceptor;

  localparam int DEB = 4;
  localparam int LCK = 8;
  localparam int CW  = 8;

  logic clk        = 1'b0;
  logic rstn       = 1'b1;
  logic coin_q_raw = 1'b0;
  logic coin_d_raw = 1'b0;
  logic quarter;
  logic dollar;
  logic reject;
  logic busy;
`ifdef COIN_ACCEPTOR_COUNT_EN
  logic [CW-1:0] coin_cnt;
  logic [CW-1:0] rej_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (DEB),
    .LOCKOUT_CYCLES  (LCK),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .coin_q_raw (coin_q_raw),
    .coin_d_raw (coin_d_raw),
    .quarter    (quarter),
    .dollar     (dollar),
    .reject     (reject),
    .busy       (busy)
`ifdef COIN_ACCEPTOR_COUNT_EN
    ,
    .coin_cnt   (coin_cnt),
    .rej_cnt    (rej_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Sensor values reach the decision logic two edges after
  // they are driven; a coin is credited once its line has been seen high,
  // with the other line low, on DEB further edges after it was first noticed.
  // After any pulse the chutes must be quiet for DEB edges, then LCK edges
  // of hold-off elapse before the acceptor listens again.
  // ---------------------------------------------------------------------------
  typedef enum {P_IDLE, P_CAND, P_PULSED, P_SETTLE, P_HOLDOFF} phase_e;

  phase_e m_phase = P_IDLE;
  bit     m_q1 = 0, m_q2 = 0, m_d1 = 0, m_d2 = 0;
  bit     m_is_q = 0;
  int     m_n = 0, m_start = 0, m_quiet = 0, m_idle_at = 0;
  bit     e_q = 0, e_d = 0, e_r = 0, e_busy = 0;
  int     e_coin = 0, e_rej = 0;
  int     cyc = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase = P_IDLE;
      m_q1 = 0; m_q2 = 0; m_d1 = 0; m_d2 = 0;
      m_n = 0; m_quiet = 0;
      e_q = 0; e_d = 0; e_r = 0; e_busy = 0;
      e_coin = 0; e_rej = 0;
      cyc = 0;
    end else begin
      bit q, d, own, other;
      q = m_q2;
      d = m_d2;
      if ((e_q || e_d) && e_coin < 255) e_coin++;
      if (e_r && e_rej < 255) e_rej++;
      e_q = 0; e_d = 0; e_r = 0;
      case (m_phase)
        P_IDLE: begin
          if (q && d) begin
            e_r = 1; m_phase = P_PULSED;
          end else if (q || d) begin
            m_phase = P_CAND; m_is_q = q; m_start = m_n;
          end
        end
        P_CAND: begin
          own   = m_is_q ? q : d;
          other = m_is_q ? d : q;
          if (!own) begin
            m_phase = P_IDLE;
          end else if (other) begin
            e_r = 1; m_phase = P_PULSED;
          end else if (m_n - m_start == DEB) begin
            if (m_is_q) e_q = 1; else e_d = 1;
            m_phase = P_PULSED;
          end
        end
        P_PULSED: begin
          m_phase = P_SETTLE; m_quiet = 0;
        end
        P_SETTLE: begin
          m_quiet = (q || d) ? 0 : m_quiet + 1;
          if (m_quiet == DEB) begin
            m_phase = P_HOLDOFF; m_idle_at = m_n + LCK;
          end
        end
        P_HOLDOFF: begin
          if (m_n == m_idle_at) m_phase = P_IDLE;
        end
        default: m_phase = P_IDLE;
      endcase
      e_busy = (m_phase != P_IDLE);
      m_q2 = m_q1; m_q1 = coin_q_raw;
      m_d2 = m_d1; m_d1 = coin_d_raw;
      m_n++;
      cyc++;
    end
  end

  // Compare process plus pulse tallies used by the directed scenarios.
  int n_q = 0, n_d = 0, n_r = 0;
  int last_q_cyc = 0, prev_q_cyc = 0, last_d_cyc = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("quarter", quarter, e_q);
      check("dollar", dollar, e_d);
      check("reject", reject, e_r);
      check("busy", busy, e_busy);
      check("one_hot_pulse", 32'(quarter) + 32'(dollar) + 32'(reject) <= 1, 1);
`ifdef COIN_ACCEPTOR_COUNT_EN
      check("coin_cnt", coin_cnt, e_coin);
      check("rej_cnt", rej_cnt, e_rej);
`endif
    end
    if (rstn) begin
      if (quarter) begin n_q++; prev_q_cyc = last_q_cyc; last_q_cyc = cyc; end
      if (dollar)  begin n_d++; last_d_cyc = cyc; end
      if (reject)  n_r++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit q, input bit d, input int n);
    coin_q_raw = q;
    coin_d_raw = d;
    tick(n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int bq, bd, br, c0;
    #1;
    rstn   = 1'b0;
    cmp_en = 1'b1;
    #2;
    check("reset_quarter", quarter, 0);
    check("reset_dollar", dollar, 0);
    check("reset_reject", reject, 0);
    check("reset_busy", busy, 0);
    tick(3);
    rstn = 1'b1;

    // Clean quarter: pulse after relative edge 6.
    bq = n_q; bd = n_d; br = n_r; c0 = cyc;
    drive(1, 0, 20);
    drive(0, 0, 30);
    check("clean_q_count", n_q - bq, 1);
    check("clean_q_latency", last_q_cyc - c0 - 1, 6);
    check("clean_no_dollar", n_d - bd, 0);
    check("clean_no_reject", n_r - br, 0);
    check("clean_idle", busy, 0);

    // Bouncing dollar: short highs are dropped, the stable one credits once.
    bq = n_q; bd = n_d; br = n_r;
    drive(0, 1, 2); drive(0, 0, 2);
    drive(0, 1, 2); drive(0, 0, 2);
    drive(0, 1, 10);
    drive(0, 0, 30);
    check("bounce_d_count", n_d - bd, 1);
    check("bounce_no_reject", n_r - br, 0);
    check("bounce_no_quarter", n_q - bq, 0);

    // Both chutes together.
    bq = n_q; bd = n_d; br = n_r;
    drive(1, 1, 6);
    drive(0, 0, 30);
    check("simul_reject", n_r - br, 1);
    check("simul_no_credit", (n_q - bq) + (n_d - bd), 0);

    // Dollar appears while a quarter is at qualify count 2.
    bq = n_q; br = n_r;
    drive(1, 0, 3);
    drive(1, 1, 6);
    drive(0, 0, 30);
    check("interf_reject", n_r - br, 1);
    check("interf_no_quarter", n_q - bq, 0);
    bq = n_q;
    drive(1, 0, 20);
    drive(0, 0, 30);
    check("interf_next_quarter", n_q - bq, 1);

    // Two quarters with a gap long enough to release: the second waits out
    // release and lockout, landing 18 edges after the first.
    bq = n_q;
    drive(1, 0, 6);
    drive(0, 0, 5);
    drive(1, 0, 20);
    drive(0, 0, 30);
    check("b2b_count", n_q - bq, 2);
    check("b2b_spacing", last_q_cyc - prev_q_cyc, 18);
    check("b2b_min_spacing", (last_q_cyc - prev_q_cyc) >= 2 + DEB + LCK, 1);

    // Reset while a dollar qualifies; the held coin is seen anew afterwards.
    bd = n_d;
    drive(0, 1, 4);
    rstn = 1'b0;
    tick(1);
    check("rst_mid_quarter", quarter, 0);
    check("rst_mid_dollar", dollar, 0);
    check("rst_mid_reject", reject, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_no_pulse", n_d - bd, 0);
    rstn = 1'b1;
    c0 = cyc;
    tick(20);
    drive(0, 0, 30);
    check("rst_d_count", n_d - bd, 1);
    check("rst_d_latency", last_d_cyc - c0 - 1, 6);
`ifdef COIN_ACCEPTOR_COUNT_EN
    check("rst_coin_cnt", coin_cnt, 1);
`endif

    // Randomized phase, model-checked every cycle.
    for (int i = 0; i < 400; i++) begin
      int sel, hold;
      sel  = $urandom_range(0, 9);
      hold = $urandom_range(1, 14);
      if ($urandom_range(0, 59) == 0) begin
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
      end
      if (sel <= 3)      drive(1, 0, hold);
      else if (sel <= 6) drive(0, 1, hold);
      else if (sel == 7) drive(1, 1, hold);
      else               drive(0, 0, hold);
    end
    drive(0, 0, 30);
    check("final_idle", busy, 0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
